// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct, zero, memready,
    output pcen, iord, memwrite, irwrite,
    output regdst, memtoreg, regwrite,
    output alusrca, alusrcb, pcsrc,
    output alucontrol, state,
    output instr_done, illegal
  );

  modport slave (
    output op, funct, zero, memready,
    input  pcen, iord, memwrite, irwrite,
    input  regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, pcsrc,
    input  alucontrol, state,
    input  instr_done, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: one state per cycle, memory-ready stalls.
// Outputs are decoded from the state register plus memready/zero/funct.
module mips_multicycle_ctrl #(
  parameter bit USE_MEMREADY = 1'b1
) (
  input logic clk,
  input logic reset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     st;
  state_t     cur;
  state_t     nx;
  logic       mr;
  logic       fn_ok;
  logic [3:0] fn_ac;
  logic       pcwrite;
  logic       branch;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       done;
  logic       ill;

  assign mr = USE_MEMREADY ? bus.memready : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) st <= FETCH;
    else        st <= nx;
  end

  // While reset is low the select decode behaves as FETCH.
  assign cur = reset ? st : FETCH;

  always_comb begin
    fn_ok = 1'b1;
    fn_ac = ALU_ADD;
    case (bus.funct)
      6'b100000: fn_ac = ALU_ADD;
      6'b100010: fn_ac = ALU_SUB;
      6'b100100: fn_ac = ALU_AND;
      6'b100101: fn_ac = ALU_OR;
      6'b100111: fn_ac = ALU_NOR;
      6'b101010: fn_ac = ALU_SLT;
      default:   fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    nx             = FETCH;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    memwrite       = 1'b0;
    irwrite        = 1'b0;
    regwrite       = 1'b0;
    done           = 1'b0;
    ill            = 1'b0;
    bus.iord       = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = ALU_ADD;
    case (cur)
      FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite     = mr;
        pcwrite     = mr;
        nx          = mr ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          6'b100011,
          6'b101011: nx = MEMADR;
          6'b000000: nx = EXECUTE;
          6'b000100: nx = BRANCH;
          6'b001000: nx = ADDIEXEC;
          6'b000010: nx = JUMP;
          default:   ill = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        nx = bus.op[3] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        nx = mr ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite     = 1'b1;
        done         = 1'b1;
      end
      MEMWR: begin
        bus.iord = 1'b1;
        memwrite = 1'b1;
        done     = mr;
        nx = mr ? FETCH : MEMWR;
      end
      EXECUTE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = fn_ac;
        ill = !fn_ok;
        nx  = fn_ok ? ALUWB : FETCH;
      end
      ALUWB: begin
        bus.regdst = 1'b1;
        regwrite   = 1'b1;
        done       = 1'b1;
      end
      BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        branch         = 1'b1;
        done           = 1'b1;
      end
      ADDIEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        nx = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        done     = 1'b1;
      end
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        done      = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  assign bus.pcen       = reset & (pcwrite | (branch & bus.zero));
  assign bus.memwrite   = reset & memwrite;
  assign bus.irwrite    = reset & irwrite;
  assign bus.regwrite   = reset & regwrite;
  assign bus.instr_done = reset & done;
  assign bus.illegal    = reset & ill;
  assign bus.state      = st;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl, plus a short
// hand sequence for the memready-ignored variant.
module tb_mips_multicycle_ctrl;
  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        m;
    logic [21:0] exp;
  } vec_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca}
  localparam logic [7:0] E0   = 8'b00000000;
  localparam logic [7:0] EF   = 8'b10010000;
  localparam logic [7:0] EA   = 8'b00000001;
  localparam logic [7:0] ERD  = 8'b01000000;
  localparam logic [7:0] EWB  = 8'b00000110;
  localparam logic [7:0] EWR  = 8'b01100000;
  localparam logic [7:0] EALU = 8'b00001010;
  localparam logic [7:0] EBT  = 8'b10000001;
  localparam logic [7:0] EJ   = 8'b10000000;
  localparam logic [7:0] EAW  = 8'b00000010;

  localparam logic [3:0] AADD = 4'b0010;
  localparam logic [3:0] ASUB = 4'b0110;
  localparam logic [3:0] AAND = 4'b0000;
  localparam logic [3:0] AOR  = 4'b0001;
  localparam logic [3:0] ASLT = 4'b0111;
  localparam logic [3:0] ANOR = 4'b1100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t q[$];

  mips_multicycle_ctrl_if c0();
  mips_multicycle_ctrl_if c1();

  assign c1.op       = c0.op;
  assign c1.funct    = c0.funct;
  assign c1.zero     = c0.zero;
  assign c1.memready = c0.memready;

  mips_multicycle_ctrl #(.USE_MEMREADY(1'b1)) u0 (
    .clk(clk), .reset(reset), .bus(c0.master)
  );
  mips_multicycle_ctrl #(.USE_MEMREADY(1'b0)) u1 (
    .clk(clk), .reset(reset), .bus(c1.master)
  );

  always #5 clk = ~clk;

  task automatic add(
    input logic r, input logic [5:0] op, input logic [5:0] fn,
    input logic z, input logic m, input logic [3:0] st,
    input logic [7:0] en, input logic [1:0] asb,
    input logic [1:0] ps, input logic [3:0] ac,
    input logic d, input logic il
  );
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.m = m;
    v.exp = {st, en, asb, ps, ac, d, il};
    q.push_back(v);
  endtask

  function automatic logic [21:0] got0();
    return {c0.state, c0.pcen, c0.iord, c0.memwrite,
            c0.irwrite, c0.regdst, c0.memtoreg,
            c0.regwrite, c0.alusrca, c0.alusrcb,
            c0.pcsrc, c0.alucontrol, c0.instr_done,
            c0.illegal};
  endfunction

  task automatic chk(input string nm, input int g, input int w);
    n_chk++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, g, w);
    end
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [3:0] ac);
    add(1, OP_R, fn, 0, 1, 4'd0, EF,   2'b01, 2'b00, AADD, 0, 0);
    add(1, OP_R, fn, 0, 1, 4'd1, E0,   2'b11, 2'b00, AADD, 0, 0);
    add(1, OP_R, fn, 0, 1, 4'd6, EA,   2'b00, 2'b00, ac,   0, 0);
    add(1, OP_R, fn, 0, 1, 4'd7, EALU, 2'b00, 2'b00, AADD, 1, 0);
  endtask

  task automatic fd(input logic [5:0] op);
    add(1, op, 6'd0, 0, 1, 4'd0, EF, 2'b01, 2'b00, AADD, 0, 0);
    add(1, op, 6'd0, 0, 1, 4'd1, E0, 2'b11, 2'b00, AADD, 0, 0);
  endtask

  initial begin
    // reset state, memready=1 must not leak through enables
    add(0, OP_R, F_ADD, 0, 1, 4'd0, E0, 2'b01, 2'b00, AADD, 0, 0);
    rtype(F_ADD, AADD);
    // lw, two memready=0 cycles in MEMRD
    fd(OP_LW);
    add(1, OP_LW, 6'd0, 0, 1, 4'd2, EA,  2'b10, 2'b00, AADD, 0, 0);
    add(1, OP_LW, 6'd0, 0, 0, 4'd3, ERD, 2'b00, 2'b00, AADD, 0, 0);
    add(1, OP_LW, 6'd0, 0, 0, 4'd3, ERD, 2'b00, 2'b00, AADD, 0, 0);
    add(1, OP_LW, 6'd0, 0, 1, 4'd3, ERD, 2'b00, 2'b00, AADD, 0, 0);
    add(1, OP_LW, 6'd0, 0, 1, 4'd4, EWB, 2'b00, 2'b00, AADD, 1, 0);
    // sw interrupted by reset while waiting
    fd(OP_SW);
    add(1, OP_SW, 6'd0, 0, 1, 4'd2, EA,  2'b10, 2'b00, AADD, 0, 0);
    add(1, OP_SW, 6'd0, 0, 0, 4'd5, EWR, 2'b00, 2'b00, AADD, 0, 0);
    add(0, OP_SW, 6'd0, 0, 0, 4'd5, E0,  2'b01, 2'b00, AADD, 0, 0);
    add(0, OP_SW, 6'd0, 0, 0, 4'd0, E0,  2'b01, 2'b00, AADD, 0, 0);
    add(0, OP_SW, 6'd0, 0, 0, 4'd0, E0,  2'b01, 2'b00, AADD, 0, 0);
    // fetch stall 4 cycles, then beq taken
    for (int i = 0; i < 4; i++)
      add(1, OP_BEQ, 6'd0, 0, 0, 4'd0, E0, 2'b01, 2'b00, AADD, 0, 0);
    fd(OP_BEQ);
    add(1, OP_BEQ, 6'd0, 1, 1, 4'd8, EBT, 2'b00, 2'b01, ASUB, 1, 0);
    fd(OP_BEQ);
    add(1, OP_BEQ, 6'd0, 0, 1, 4'd8, EA,  2'b00, 2'b01, ASUB, 1, 0);
    fd(OP_J);
    add(1, OP_J, 6'd0, 0, 1, 4'd11, EJ, 2'b00, 2'b10, AADD, 1, 0);
    fd(OP_ADI);
    add(1, OP_ADI, 6'd0, 0, 1, 4'd9,  EA,  2'b10, 2'b00, AADD, 0, 0);
    add(1, OP_ADI, 6'd0, 0, 1, 4'd10, EAW, 2'b00, 2'b00, AADD, 1, 0);
    // illegal op, then illegal funct
    add(1, OP_BAD, 6'd0, 0, 1, 4'd0, EF, 2'b01, 2'b00, AADD, 0, 0);
    add(1, OP_BAD, 6'd0, 0, 1, 4'd1, E0, 2'b11, 2'b00, AADD, 0, 1);
    fd(OP_R);
    add(1, OP_R, 6'd0, 0, 1, 4'd6, EA, 2'b00, 2'b00, AADD, 0, 1);
    rtype(F_SUB, ASUB);
    rtype(F_SLT, ASLT);
    rtype(F_NOR, ANOR);
    rtype(F_AND, AAND);
    rtype(F_OR,  AOR);
    fd(OP_SW);
    add(1, OP_SW, 6'd0, 0, 1, 4'd2, EA,  2'b10, 2'b00, AADD, 0, 0);
    add(1, OP_SW, 6'd0, 0, 1, 4'd5, EWR, 2'b00, 2'b00, AADD, 1, 0);
    add(1, OP_SW, 6'd0, 0, 1, 4'd0, EF,  2'b01, 2'b00, AADD, 0, 0);

    c0.op = OP_R; c0.funct = F_ADD;
    c0.zero = 1'b0; c0.memready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    foreach (q[i]) begin
      reset       = q[i].r;
      c0.op       = q[i].op;
      c0.funct    = q[i].fn;
      c0.zero     = q[i].z;
      c0.memready = q[i].m;
      @(negedge clk);
      n_chk++;
      if (got0() !== q[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %h want %h",
                 i, got0(), q[i].exp);
      end
      @(posedge clk);
      #1;
    end

    // memready ignored: lw runs straight through with memready=0
    reset = 1'b0;
    c0.op = OP_LW; c0.memready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("nomr_state%0d", k), int'(c1.state), k);
      if (k == 0) begin
        chk("nomr_irwrite", int'(c1.irwrite), 1);
        chk("nomr_pcen", int'(c1.pcen), 1);
      end
      if (k == 3) chk("nomr_iord", int'(c1.iord), 1);
      if (k == 4) chk("nomr_regwrite", int'(c1.regwrite), 1);
      chk($sformatf("mr_stall%0d", k), int'(c0.state), 0);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: shared ALU, unified instruction/data memory, instruction register.
- Decodes op/funct and drives all mux selects, write enables and the 4-bit ALU control, one state per cycle.
- Stalls on a memory-ready handshake.
- Sits beside the multicycle datapath, in place of the single-cycle combinational controller.

Parameters:
- USE_MEMREADY, 1, 1 = wait on memready in FETCH/MEMRD/MEMWR; 0 = memready ignored (treated as 1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge forces FETCH.
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- memready  in  1  memory completes access this cycle.
- pcen  out  1  PC load = pcwrite | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = data register, 0 = ALU result register.
- regwrite  out  1  register file write.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  00 = ALU result, 01 = ALU result register, 10 = jump target.
- alucontrol  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- state  out  4  current state code (debug).
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  one-cycle pulse on an unsupported op/funct.

Behaviour:
- Codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH next cycle and pulse illegal.
- Reset:
  - reset=0 at an edge sets state to FETCH; applies mid-instruction, with no write issued in that cycle.
  - While reset=0, every enable is 0: pcen, memwrite, irwrite, regwrite.
  - Selects follow the FETCH decode; instr_done and illegal are 0.
- Default outputs: all 0, alucontrol=0010.
- FETCH:
  - alusrcb=01, alucontrol=ADD.
  - irwrite=pcen=memready; stays in FETCH until memready=1, then goes to DECODE.
- DECODE:
  - alusrcb=11, ADD.
  - Next state by op: 100011 lw / 101011 sw -> MEMADR; 000000 -> EXECUTE; 000100 beq -> BRANCH; 001000 addi -> ADDIEXEC; 000010 j -> JUMP.
  - Any other op -> FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, ADD; lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1; waits for memready, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1; next FETCH.
- MEMWR:
  - iord=1; memwrite=1 held every cycle of the wait.
  - On memready=1: instr_done=1, next FETCH.
- EXECUTE:
  - alusrca=1, alusrcb=00.
  - alucontrol from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - Other funct: illegal=1, next FETCH, no ALUWB. Valid funct -> ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1; next FETCH.
- BRANCH:
  - alusrca=1, SUB, pcsrc=01, branch=1 (pcen=zero), instr_done=1; next FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, ADD; next ADDIWB.
- ADDIWB: regwrite=1 (regdst=0, memtoreg=0), instr_done=1; next FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1; next FETCH.
- Latency with memready tied 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles; each memready=0 cycle adds one.
- USE_MEMREADY=0: waiting states never stall.
- Outputs depend only on state, memready, zero and funct. The last three are used only where listed above.

Test Plan:
- Reset held low 3 cycles mid-MEMWR (memready=0) -> memwrite=0 while reset low; state=0 on first cycle after release; no instr_done.
- R-type add (op=000000, funct=100000), memready=1 -> states 0,1,6,7; alucontrol=0010 in EXECUTE; regdst=regwrite=1 and instr_done=1 in ALUWB.
- lw with memready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; iord=1 throughout MEMRD; memtoreg=regwrite=1 in MEMWB; 7 cycles total.
- beq: zero=1 -> pcen=1, pcsrc=01 in state 8; repeat with zero=0 -> pcen=0; both return to FETCH after 3 cycles.
- Illegal op 111111 -> illegal pulse in DECODE, state 0 next, no regwrite/memwrite. Funct 000000 on R-type -> illegal pulse in EXECUTE, ALUWB skipped.
- FETCH with memready=0 for 4 cycles -> irwrite=pcen=0 for 4 cycles, both 1 on cycle 5. With USE_MEMREADY=0 -> irwrite=pcen=1 on cycle 1 regardless of memready.
